mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester (IF) and the data-memory requester (DM).
- Sequences each access through a request/acknowledge handshake to the memory.
- Returns read data and completion pulses to the requester that issued the access.
- Aborts any access that is not acknowledged in time.
- Drives MEM_RDY to the hazard unit, which stalls the pipeline while a data access is outstanding.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data memory (DM) requesters.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on IF/DM ties instead of fixed DM priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IF_REQ,
  input  logic [ADDR_W-1:0]   IF_ADDR,
  output logic                IF_DONE,
  output logic [DATA_W-1:0]   IF_RDATA,
  input  logic                DM_REQ,
  input  logic                DM_WE,
  input  logic [DATA_W/8-1:0] DM_BE,
  input  logic [ADDR_W-1:0]   DM_ADDR,
  input  logic [DATA_W-1:0]   DM_WDATA,
  output logic                DM_DONE,
  output logic [DATA_W-1:0]   DM_RDATA,
  output logic                ERR,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [DATA_W/8-1:0] MEM_BE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  input  logic                MEM_ACK,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  output logic                MEM_RDY,
  output logic                BUSY
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  logic             r_owner_dm;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_dm;
  logic             w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_dm;
  // On a tie, the requester that did not own the previous access wins.
  assign w_grant_dm = DM_REQ && (!IF_REQ || !r_last_dm);
`else
  assign w_grant_dm = DM_REQ;
`endif

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == TMO_VAL);
  assign MEM_RDY   = !DM_REQ || DM_DONE;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_owner_dm <= 1'b0;
      r_cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_dm  <= 1'b0;
`endif
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_BE     <= '0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      IF_DONE    <= 1'b0;
      DM_DONE    <= 1'b0;
      IF_RDATA   <= '0;
      DM_RDATA   <= '0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      IF_DONE <= 1'b0;
      DM_DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IF_REQ || DM_REQ) begin
            r_owner_dm <= w_grant_dm;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_dm  <= w_grant_dm;
`endif
            r_cnt      <= '0;
            MEM_REQ    <= 1'b1;
            BUSY       <= 1'b1;
            ERR        <= 1'b0;
            r_state    <= S_BUSY;
            if (w_grant_dm) begin
              MEM_WE    <= DM_WE;
              MEM_BE    <= DM_BE;
              MEM_ADDR  <= DM_ADDR;
              MEM_WDATA <= DM_WDATA;
            end else begin
              MEM_WE    <= 1'b0;
              MEM_BE    <= '1;
              MEM_ADDR  <= IF_ADDR;
              MEM_WDATA <= '0;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_nxt;
          if (MEM_ACK || w_timeout) begin
            MEM_REQ <= 1'b0;
            ERR     <= !MEM_ACK;
            r_state <= S_RESP;
            if (r_owner_dm) begin
              DM_DONE  <= 1'b1;
              DM_RDATA <= MEM_ACK ? MEM_RDATA : '0;
            end else begin
              IF_DONE  <= 1'b1;
              IF_RDATA <= MEM_ACK ? MEM_RDATA : '0;
            end
          end
        end
        S_RESP: begin
          ERR     <= 1'b0;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a randomized memory responder
// that predicts grant owner and response, and a monitor that checks every DONE pulse.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TMO = 6, N_TXN = 40;

  logic          CLK = 1'b0, RST_N = 1'b0;
  logic          IF_REQ = 1'b0, DM_REQ = 1'b0, DM_WE = 1'b0, MEM_ACK = 1'b0;
  logic [AW-1:0] IF_ADDR = '0, DM_ADDR = '0;
  logic [DW-1:0] DM_WDATA = '0, MEM_RDATA = '0;
  logic [3:0]    DM_BE = '0;
  logic          IF_DONE, DM_DONE, ERR, MEM_REQ, MEM_WE, MEM_RDY, BUSY;
  logic [DW-1:0] IF_RDATA, DM_RDATA, MEM_WDATA;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_BE;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DONE(IF_DONE), .IF_RDATA(IF_RDATA),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_BE(DM_BE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_DONE(DM_DONE), .DM_RDATA(DM_RDATA), .ERR(ERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .MEM_RDY(MEM_RDY), .BUSY(BUSY)
  );

  typedef struct { bit dm; logic [DW-1:0] rd; bit err; } exp_t;
  exp_t sbq[$];

  int unsigned n_cmp = 0, n_fail = 0;
  bit          resp_en = 1'b0;
  int unsigned force_d = 0;
  logic [DW-1:0] force_rd = '0;
  bit          last_dm_m = 1'b0;

  logic [AW-1:0] cur_if_addr = '0, cur_dm_addr = '0;
  logic          cur_dm_we = 1'b0;
  logic [3:0]    cur_dm_be = '0;
  logic [DW-1:0] cur_dm_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic if_txn(input logic [AW-1:0] a);
    bit got = 1'b0;
    @(posedge CLK); #1;
    cur_if_addr = a; IF_ADDR = a; IF_REQ = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (IF_DONE) got = 1'b1;
    end
    check("if_done_seen", 64'(got), 64'(1));
    @(posedge CLK); #1;
    IF_REQ = 1'b0;
  endtask

  task automatic dm_txn(input logic [AW-1:0] a, input logic we, input logic [3:0] be,
                        input logic [DW-1:0] wd);
    bit got = 1'b0;
    @(posedge CLK); #1;
    cur_dm_addr = a; cur_dm_we = we; cur_dm_be = be; cur_dm_wdata = wd;
    DM_ADDR = a; DM_WE = we; DM_BE = be; DM_WDATA = wd; DM_REQ = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (DM_DONE) got = 1'b1;
    end
    check("dm_done_seen", 64'(got), 64'(1));
    @(posedge CLK); #1;
    DM_REQ = 1'b0;
  endtask

  // Memory model: predicts the owner of each grant, holds ACK off for a chosen delay
  // (or forever, forcing a timeout) and queues the response the requester must see.
  initial begin : responder
    bit active = 1'b0, chk_drop = 1'b0, prev_req = 1'b0, lvl_if = 1'b0, lvl_dm = 1'b0, own_dm = 1'b0;
    int unsigned bc = 0, d = 0;
    logic [DW-1:0] rd;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MEM_ACK) MEM_ACK = 1'b0;
      if (!RST_N) begin
        active = 1'b0; chk_drop = 1'b0; last_dm_m = 1'b0;
      end else begin
        if (chk_drop) begin
          check("mem_req_drop", 64'(MEM_REQ), 64'(0));
          chk_drop = 1'b0;
        end
        if (active) begin
          bc++;
        end else if (resp_en && MEM_REQ && !prev_req) begin
          check("grant_has_req", 64'(lvl_if || lvl_dm), 64'(1));
`ifdef ARB_ROUND_ROBIN_EN
          own_dm = (lvl_if && lvl_dm) ? !last_dm_m : lvl_dm;
`else
          own_dm = lvl_dm;
`endif
          last_dm_m = own_dm;
          active = 1'b1; bc = 1;
          d = (force_d != 0) ? force_d : $urandom_range(1, TMO + 2);
        end else if (resp_en && !MEM_REQ && $urandom_range(0, 7) == 0) begin
          MEM_ACK = 1'b1; MEM_RDATA = $urandom;
        end
        if (active) begin
          if (own_dm) begin
            check("dm_fields", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR}, {27'd0, 1'b1, cur_dm_we, cur_dm_be, cur_dm_addr});
            check("dm_wdata", 64'(MEM_WDATA), 64'(cur_dm_wdata));
          end else begin
            check("if_fields", {MEM_REQ, MEM_WE, MEM_ADDR}, {30'd0, 1'b1, 1'b0, cur_if_addr});
          end
          if (d <= TMO && bc == d) begin
            rd = (force_d != 0) ? force_rd : $urandom;
            MEM_ACK = 1'b1; MEM_RDATA = rd;
            e.dm = own_dm; e.rd = rd; e.err = 1'b0;
            sbq.push_back(e);
            active = 1'b0; chk_drop = 1'b1;
          end else if (d > TMO && bc == TMO) begin
            e.dm = own_dm; e.rd = '0; e.err = 1'b1;
            sbq.push_back(e);
            active = 1'b0; chk_drop = 1'b1;
          end
        end
      end
      prev_req = MEM_REQ; lvl_if = IF_REQ; lvl_dm = DM_REQ;
    end
  end

  initial begin : monitor
    exp_t e;
    logic [DW-1:0] m_if = '0, m_dm = '0;
    bit exp_dmd;
    forever begin
      @(negedge CLK);
      exp_dmd = 1'b0;
      if (!RST_N) begin
        m_if = '0; m_dm = '0;
        check("rst_no_done", 64'({IF_DONE, DM_DONE}), 64'(0));
      end else begin
        if (IF_DONE || DM_DONE) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 64'({IF_DONE, DM_DONE}), 64'(0));
          end else begin
            e = sbq.pop_front();
            exp_dmd = e.dm;
            check("done_owner", 64'({IF_DONE, DM_DONE}), e.dm ? 64'(1) : 64'(2));
            check("err", 64'(ERR), 64'(e.err));
            if (e.dm) m_dm = e.rd; else m_if = e.rd;
            check("if_rdata", 64'(IF_RDATA), 64'(m_if));
            check("dm_rdata", 64'(DM_RDATA), 64'(m_dm));
          end
        end else begin
          check("err_no_done", 64'(ERR), 64'(0));
        end
      end
      check("mem_rdy", 64'(MEM_RDY), 64'(!DM_REQ || exp_dmd));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit got;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", 64'({MEM_REQ, BUSY, IF_DONE, DM_DONE, ERR, MEM_WE, MEM_BE}), 64'(0));
    check("rst_data", {IF_RDATA, DM_RDATA}, 64'(0));
    check("rst_addr", {MEM_ADDR, MEM_WDATA}, 64'(0));
    check("rst_rdy", 64'(MEM_RDY), 64'(1));
    #1 RST_N = 1'b1; resp_en = 1'b1;

    // Ties first so the round-robin build sees DM win the first tie after reset.
    for (int t = 0; t < 3; t++)
      fork
        if_txn(32'h1000 + 32'(t));
        dm_txn(32'h2000 + 32'(t), 1'b0, 4'hF, '0);
      join

    force_d = 2; force_rd = 32'hDEADBEEF;
    dm_txn(32'h0000_0040, 1'b0, 4'hF, '0);
    force_d = 5;
    dm_txn(32'h0000_0080, 1'b1, 4'b0011, 32'hCAFE_F00D);
    force_d = TMO + 1;
    if_txn(32'h0000_0100);
    force_d = 0;
    dm_txn(32'h0000_0104, 1'b0, 4'hF, '0);

    fork
      for (int i = 0; i < N_TXN; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        if_txn($urandom);
      end
      for (int j = 0; j < N_TXN; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        dm_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
    join

    // Reset asserted mid-access: everything clears, and the held fetch is re-granted.
    resp_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1 cur_if_addr = 32'hABCD_0000; IF_ADDR = 32'hABCD_0000; IF_REQ = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      if (MEM_REQ) got = 1'b1;
    end
    check("pre_rst_grant", 64'(got), 64'(1));
    @(negedge CLK); #1 RST_N = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({MEM_REQ, BUSY, IF_DONE, DM_DONE, ERR, MEM_WE, MEM_BE}), 64'(0));
    check("async_rst_data", {IF_RDATA, DM_RDATA}, 64'(0));
    check("async_rst_addr", {MEM_ADDR, MEM_WDATA}, 64'(0));
    check("async_rst_rdy", 64'(MEM_RDY), 64'(1));
    @(negedge CLK); #1 RST_N = 1'b1; resp_en = 1'b1;
    @(negedge CLK);
    check("post_rst_grant", {31'd0, MEM_REQ, MEM_ADDR}, {31'd0, 1'b1, 32'hABCD_0000});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (IF_DONE) got = 1'b1;
    end
    check("post_rst_done", 64'(got), 64'(1));
    @(posedge CLK); #1 IF_REQ = 1'b0;

    // Spurious ACK while idle must be ignored.
    resp_en = 1'b0;
    repeat (3) @(negedge CLK);
    #2 MEM_ACK = 1'b1; MEM_RDATA = 32'h5555_AAAA;
    repeat (3) begin
      @(negedge CLK);
      check("spurious_ack", 64'({IF_DONE, DM_DONE, BUSY, MEM_REQ}), 64'(0));
    end

    repeat (3) @(negedge CLK);
    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
